// File: rtl/mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the memory_system write path.
//   - DATA_W_DEF / ADDR_W_DEF : default data and address widths
//   - MEM_DEPTH               : number of entries in memory_system
//   - state_e                 : write-controller FSM state encoding
// ---------------------------------------------------------------------------
package mem_ctrl_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned ADDR_W_DEF = 2;
   localparam int unsigned MEM_DEPTH  = 4;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      PRESS_WAIT   = 3'd1,
      FIRE         = 3'd2,
      HELD         = 3'd3,
      RELEASE_WAIT = 3'd4
   } state_e;

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// One-bit two-flop synchronizer with asynchronous active-low clear.
//   clk   : destination clock
//   rst_n : asynchronous active-low clear (both stages go to 0)
//   d     : asynchronous input
//   q     : synchronized output (two clk cycles of latency)
// ---------------------------------------------------------------------------
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/mem_write_ctrl.sv
// ---------------------------------------------------------------------------
// mem_write_ctrl
// Debounced push-button write controller for memory_system. Each confirmed
// press captures data_in and an address (addr_in, or the internal write
// pointer when auto_inc=1) and issues exactly one single-cycle store strobe.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   btn_raw  : raw, unsynchronized push-button
//   data_in  : switch data to store
//   addr_in  : switch address, used when auto_inc=0
//   auto_inc : 1 = use internal write pointer (0,1,2,3,0,...)
//   store    : registered single-cycle write strobe
//   data_out : captured data, held after the strobe
//   addr_out : captured address, held after the strobe
//   busy     : high in every state except IDLE
//   wr_count : number of strobes issued, wraps 255->0
// ---------------------------------------------------------------------------
module mem_write_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned DATA_W          = DATA_W_DEF,
   parameter int unsigned ADDR_W          = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              btn_raw,
   input  logic [DATA_W-1:0] data_in,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic              auto_inc,
   output logic              store,
   output logic [DATA_W-1:0] data_out,
   output logic [ADDR_W-1:0] addr_out,
   output logic              busy,
   output logic [7:0]        wr_count
);

   localparam logic [15:0]       CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
   localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(MEM_DEPTH - 1);

   logic btn_s;

   sync_2ff u_btn_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (btn_raw),
      .q     (btn_s)
   );

   state_e            state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              inc_q, inc_d;
   logic [7:0]        wr_cnt_q, wr_cnt_d;
   logic              store_q, store_d;

   // auto_inc is latched at the capture edge so that the pointer advance in
   // FIRE follows the mode used for this write, not a later toggle.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ptr_d    = ptr_q;
      data_d   = data_q;
      addr_d   = addr_q;
      inc_d    = inc_q;
      wr_cnt_d = wr_cnt_q;
      store_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (btn_s) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!btn_s) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = FIRE;
               store_d = 1'b1;
               data_d  = data_in;
               addr_d  = auto_inc ? ptr_q : addr_in;
               inc_d   = auto_inc;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         FIRE: begin
            state_d  = HELD;
            wr_cnt_d = wr_cnt_q + 8'd1;
            if (inc_q) begin
               ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
            end
         end
         HELD: begin
            if (!btn_s) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (btn_s) begin
               state_d = HELD;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         ptr_q    <= '0;
         data_q   <= '0;
         addr_q   <= '0;
         inc_q    <= 1'b0;
         wr_cnt_q <= '0;
         store_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ptr_q    <= ptr_d;
         data_q   <= data_d;
         addr_q   <= addr_d;
         inc_q    <= inc_d;
         wr_cnt_q <= wr_cnt_d;
         store_q  <= store_d;
      end
   end

   assign store    = store_q;
   assign data_out = data_q;
   assign addr_out = addr_q;
   assign busy     = (state_q != IDLE);
   assign wr_count = wr_cnt_q;

endmodule

// File: tb/tb_mem_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_write_ctrl
// Self-checking bench for mem_write_ctrl. A sample-level reference model
// watches btn_raw: a press is confirmed after D+1 consecutive high samples
// while armed, and the controller re-arms after D+1 consecutive low samples.
// Each confirmed press predicts one strobe two edges later, with its data,
// address and pre-strobe write count.
// ---------------------------------------------------------------------------
module tb_mem_write_ctrl;

   localparam int D = 16;

   logic       clk;
   logic       rst_n;
   logic       btn_raw;
   logic [7:0] data_in;
   logic [1:0] addr_in;
   logic       auto_inc;
   logic       store;
   logic [7:0] data_out;
   logic [1:0] addr_out;
   logic       busy;
   logic [7:0] wr_count;

   mem_write_ctrl #(
      .DEBOUNCE_CYCLES (D),
      .DATA_W          (8),
      .ADDR_W          (2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_raw  (btn_raw),
      .data_in  (data_in),
      .addr_in  (addr_in),
      .auto_inc (auto_inc),
      .store    (store),
      .data_out (data_out),
      .addr_out (addr_out),
      .busy     (busy),
      .wr_count (wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int         edge_n;
      logic [7:0] data;
      logic [1:0] addr;
      logic [7:0] wr;
   } exp_t;

   exp_t       exp_q[$];
   int         ecnt = 0;
   int         hi_run, lo_run;
   bit         armed;
   logic [1:0] mptr;
   logic [7:0] mcount;
   logic [7:0] mlast_data;
   logic [1:0] mlast_addr;

   always @(posedge clk or negedge rst_n) begin : model
      exp_t e;
      if (!rst_n) begin
         armed      = 1'b1;
         hi_run     = 0;
         lo_run     = 0;
         mptr       = 2'd0;
         mcount     = 8'd0;
         mlast_data = 8'd0;
         mlast_addr = 2'd0;
         exp_q.delete();
      end else begin
         if (btn_raw) begin
            hi_run++;
            lo_run = 0;
            if (armed && hi_run == D + 1) begin
               e.edge_n = ecnt + 3;
               e.data   = data_in;
               e.addr   = auto_inc ? mptr : addr_in;
               e.wr     = mcount;
               exp_q.push_back(e);
               mlast_data = e.data;
               mlast_addr = e.addr;
               mcount     = mcount + 8'd1;
               if (auto_inc) mptr = 2'((mptr + 1) % 4);
               armed = 1'b0;
            end
         end else begin
            lo_run++;
            hi_run = 0;
            if (!armed && lo_run == D + 1) armed = 1'b1;
         end
         ecnt++;
      end
   end

   // ---------------- strobe monitor ----------------
   always @(posedge clk) begin : monitor
      exp_t e;
      #1;
      if (rst_n) begin
         if (exp_q.size() != 0 && exp_q[0].edge_n < ecnt) begin
            chk("missed_strobe_edge", 32'(ecnt), 32'(exp_q[0].edge_n));
            void'(exp_q.pop_front());
         end
         if (store) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_strobe", 32'(store), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("strobe_edge", 32'(ecnt), 32'(e.edge_n));
               chk("strobe_data", 32'(data_out), 32'(e.data));
               chk("strobe_addr", 32'(addr_out), 32'(e.addr));
               chk("strobe_wr_count", 32'(wr_count), 32'(e.wr));
               chk("strobe_busy", 32'(busy), 32'd1);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic level, input int n);
      btn_raw = level;
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int hold, input int gap);
      drive(1'b1, hold);
      drive(1'b0, gap);
   endtask

   task automatic chk_held(input string tag);
      chk({tag, "_data_held"}, 32'(data_out), 32'(mlast_data));
      chk({tag, "_addr_held"}, 32'(addr_out), 32'(mlast_addr));
      chk({tag, "_wr_count"},  32'(wr_count), 32'(mcount));
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- directed + random sequence ----------------
   initial begin : stim
      logic [7:0] d5;
      rst_n    = 1'b0;
      btn_raw  = 1'b0;
      data_in  = 8'h00;
      addr_in  = 2'd0;
      auto_inc = 1'b0;
      #2;
      chk("rst_store",    32'(store),    32'd0);
      chk("rst_busy",     32'(busy),     32'd0);
      chk("rst_data",     32'(data_out), 32'd0);
      chk("rst_addr",     32'(addr_out), 32'd0);
      chk("rst_wr_count", 32'(wr_count), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle: no strobe may appear, outputs stay at reset values.
      repeat (50) @(negedge clk);
      chk("idle_busy",     32'(busy),     32'd0);
      chk("idle_store",    32'(store),    32'd0);
      chk("idle_wr_count", 32'(wr_count), 32'd0);
      chk("idle_data",     32'(data_out), 32'd0);

      // Plain press: A5 to address 2.
      data_in = 8'hA5; addr_in = 2'd2; auto_inc = 1'b0;
      drive(1'b1, D + 3);
      chk("hold_busy", 32'(busy), 32'd1);
      data_in = 8'h5A; addr_in = 2'd1;   // late changes must not affect the write
      drive(1'b1, 20);
      drive(1'b0, D + 10);
      chk("plain_data",  32'(data_out), 32'hA5);
      chk("plain_addr",  32'(addr_out), 32'd2);
      chk("plain_count", 32'(wr_count), 32'd1);
      chk("plain_busy",  32'(busy),     32'd0);

      // Bounce on press: 5 high, 2 low, 30 high -> one strobe.
      data_in = 8'h3C; addr_in = 2'd3;
      drive(1'b1, 5);
      drive(1'b0, 2);
      press(30, D + 10);
      chk("bounce_count", 32'(wr_count), 32'd2);
      chk_held("bounce");

      // Boundary: exactly D high samples is rejected, D+1 is accepted.
      data_in = 8'hE1; addr_in = 2'd1;
      press(D, D + 10);
      chk("short_count", 32'(wr_count), 32'd2);
      press(D + 1, D + 10);
      chk("exact_count", 32'(wr_count), 32'd3);
      chk_held("exact");

      // Long hold with two 3-cycle release glitches -> one strobe.
      data_in = 8'h77; addr_in = 2'd0;
      drive(1'b1, 60);
      drive(1'b0, 3);
      drive(1'b1, 57);
      drive(1'b0, 3);
      drive(1'b1, 77);
      drive(1'b0, D + 10);
      chk("glitch_count", 32'(wr_count), 32'd4);
      chk_held("glitch");

      // Auto-increment: five presses fill 0,1,2,3,0.
      auto_inc = 1'b1;
      addr_in  = 2'd3;
      for (int i = 0; i < 5; i++) begin
         d5 = 8'(8'h11 * (i + 1));
         data_in = d5;
         press(D + 8, D + 8);
         chk("auto_addr", 32'(addr_out), 32'(i % 4));
         chk("auto_data", 32'(data_out), 32'(d5));
      end
      chk("auto_count", 32'(wr_count), 32'd9);

      // Reset during FIRE (pointer currently 1).
      data_in = 8'h99;
      btn_raw = 1'b1;
      repeat (D + 3) @(posedge clk);
      #1;
      chk("fire_store", 32'(store), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("fire_rst_store", 32'(store),    32'd0);
      chk("fire_rst_count", 32'(wr_count), 32'd0);
      chk("fire_rst_busy",  32'(busy),     32'd0);
      btn_raw = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (D + 5) @(negedge clk);
      data_in = 8'h42;
      press(D + 8, D + 8);
      chk("post_rst_addr",  32'(addr_out), 32'd0);
      chk("post_rst_data",  32'(data_out), 32'h42);
      chk("post_rst_count", 32'(wr_count), 32'd1);

      // Randomized presses, glitches and modes.
      for (int i = 0; i < 16; i++) begin
         data_in  = 8'($urandom);
         addr_in  = 2'($urandom);
         auto_inc = 1'($urandom);
         if ($urandom_range(0, 3) == 0)
            drive(1'b1, $urandom_range(1, D));
         drive(1'b0, $urandom_range(D + 3, D + 12));
         drive(1'b1, $urandom_range(D + 1, D + 40));
         if ($urandom_range(0, 1) == 1) begin
            drive(1'b0, $urandom_range(1, D));
            drive(1'b1, $urandom_range(1, 20));
         end
         data_in = 8'($urandom);
         addr_in = 2'($urandom);
         drive(1'b0, D + 6);
         chk_held("rand");
      end

      repeat (5) @(negedge clk);
      chk("pending_strobes", 32'(exp_q.size()), 32'd0);
      chk("final_count",     32'(wr_count),     32'(mcount));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
